// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: AXI4-Lite slave that scans an N-digit multiplexed
// seven-segment display, with frame-synchronous shadow registers.
//
// Ports:
//   ACLK, ARESET     clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*  AXI4-Lite write channels (single-beat, one in flight)
//   S_AXI_AR*/R*     AXI4-Lite read channels (single-beat, one in flight)
//   an               digit enables, one-hot when lit
//   seg              segments a..g, bit0 = a
//   dp               decimal point
//
// Register map (byte offsets):
//   0x00 CTRL      [0] EN, [1] RAW
//   0x04 DATA      hex nibble k -> digit k, or RAW bits [7k+6:7k]
//   0x08 MASK      [7:0] DP per digit, [15:8] BLANK per digit
//   0x0C PRESCALE  ACLK cycles per digit (0 is stored as 1)
//   0x10 STATUS    [2:0] digit index, [31:16] frame count (read-only)
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int ADDR_WIDTH   = 5,
    parameter int PRESCALE_RST = 100000,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int         IW    = ADDR_WIDTH - 2;
    localparam logic       UNLIT = (ACTIVE_LOW != 0);
    localparam logic [2:0] LAST  = 3'(NUM_DIGITS - 1);

    localparam logic [IW-1:0] A_CTRL   = IW'(0);
    localparam logic [IW-1:0] A_DATA   = IW'(1);
    localparam logic [IW-1:0] A_MASK   = IW'(2);
    localparam logic [IW-1:0] A_PRE    = IW'(3);
    localparam logic [IW-1:0] A_STATUS = IW'(4);

    // programmer-visible registers
    logic        ctrl_en;
    logic        ctrl_raw;
    logic [31:0] data_reg;
    logic [15:0] mask_reg;
    logic [31:0] prescale;

    // frame-synchronous copies used by the scanner
    logic        raw_sh;
    logic [31:0] data_sh;
    logic [15:0] mask_sh;

    // scanner state
    logic [31:0] cnt;
    logic [2:0]  idx;
    logic [15:0] frame;

    logic        bvalid;
    logic [1:0]  bresp;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic          wr_fire;
    logic          ar_fire;
    logic [31:0]   wr_old;
    logic [31:0]   wr_m;
    logic          en_nxt;
    logic          raw_nxt;
    logic          en_rise;
    logic          tick;
    logic          over;
    logic          wrap;
    logic          load_sh;
    logic [31:0]   rd_mux;
    logic [1:0]    rd_resp;

    logic                  unused_addr;
    assign unused_addr = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_idx  = S_AXI_AWADDR[ADDR_WIDTH-1:2];
    assign rd_idx  = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign wr_fire = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid;
    assign ar_fire = S_AXI_ARVALID & ~rvalid;

    assign S_AXI_AWREADY = wr_fire & ~ARESET;
    assign S_AXI_WREADY  = wr_fire & ~ARESET;
    assign S_AXI_ARREADY = ar_fire & ~ARESET;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = rresp;

    function automatic logic [31:0] merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // strobe-merge against whichever register the write addresses
    always_comb begin
        wr_old = 32'd0;
        case (wr_idx)
            A_CTRL:  wr_old = {30'd0, ctrl_raw, ctrl_en};
            A_DATA:  wr_old = data_reg;
            A_MASK:  wr_old = {16'd0, mask_reg};
            A_PRE:   wr_old = prescale;
            default: wr_old = 32'd0;
        endcase
        wr_m = merge(wr_old, S_AXI_WDATA, S_AXI_WSTRB);
    end

    always_comb begin
        en_nxt  = ctrl_en;
        raw_nxt = ctrl_raw;
        if (wr_fire && wr_idx == A_CTRL) begin
            en_nxt  = wr_m[0];
            raw_nxt = wr_m[1];
        end
    end

    // Shadows load on the enabling write itself so the very first
    // displayed digit already shows the current DATA/MASK/RAW.
    assign en_rise = en_nxt & ~ctrl_en;
    assign over    = cnt >= prescale;
    assign tick    = ctrl_en & (cnt == prescale - 32'd1);
    assign wrap    = tick & (idx == LAST);
    assign load_sh = wrap | en_rise;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ctrl_en  <= 1'b0;
            ctrl_raw <= 1'b0;
            data_reg <= 32'd0;
            mask_reg <= 16'd0;
            prescale <= 32'(PRESCALE_RST);
            bvalid   <= 1'b0;
            bresp    <= 2'b00;
        end else begin
            ctrl_en  <= en_nxt;
            ctrl_raw <= raw_nxt;
            if (bvalid && S_AXI_BREADY) bvalid <= 1'b0;
            if (wr_fire) begin
                bvalid <= 1'b1;
                bresp  <= (wr_idx >= A_STATUS) ? 2'b10 : 2'b00;
                if (wr_idx == A_DATA) data_reg <= wr_m;
                if (wr_idx == A_MASK) mask_reg <= wr_m[15:0];
                if (wr_idx == A_PRE)
                    prescale <= (wr_m == 32'd0) ? 32'd1 : wr_m;
            end
        end
    end

    always_comb begin
        rd_mux  = 32'd0;
        rd_resp = 2'b00;
        case (rd_idx)
            A_CTRL:   rd_mux = {30'd0, ctrl_raw, ctrl_en};
            A_DATA:   rd_mux = data_reg;
            A_MASK:   rd_mux = {16'd0, mask_reg};
            A_PRE:    rd_mux = prescale;
            A_STATUS: rd_mux = {frame, 13'd0, idx};
            default:  rd_resp = 2'b10;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid <= 1'b0;
            rdata  <= 32'd0;
            rresp  <= 2'b00;
        end else begin
            if (rvalid && S_AXI_RREADY) rvalid <= 1'b0;
            if (ar_fire) begin
                rvalid <= 1'b1;
                rdata  <= rd_mux;
                rresp  <= rd_resp;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            raw_sh  <= 1'b0;
            data_sh <= 32'd0;
            mask_sh <= 16'd0;
        end else if (load_sh) begin
            raw_sh  <= raw_nxt;
            data_sh <= data_reg;
            mask_sh <= mask_reg;
        end
    end

    // A shrunken PRESCALE can leave cnt past terminal; restart it
    // without a tick so the digit is not skipped.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cnt   <= 32'd0;
            idx   <= 3'd0;
            frame <= 16'd0;
        end else if (!ctrl_en) begin
            cnt   <= 32'd0;
            idx   <= 3'd0;
            frame <= 16'd0;
        end else if (over) begin
            cnt <= 32'd0;
        end else if (tick) begin
            cnt <= 32'd0;
            if (wrap) begin
                idx   <= 3'd0;
                frame <= frame + 16'd1;
            end else begin
                idx <= idx + 3'd1;
            end
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    logic [NUM_DIGITS-1:0] an_lit;
    logic [6:0]            seg_lit;
    logic                  dp_lit;
    logic                  blank;
    logic [3:0]            nib;
    logic [6:0]            raw_bits;

    always_comb begin
        blank    = mask_sh[{1'b1, idx}];
        nib      = data_sh[{idx, 2'b00} +: 4];
        raw_bits = 7'(data_sh >> (32'(idx) * 32'd7));
        an_lit   = '0;
        seg_lit  = 7'd0;
        dp_lit   = 1'b0;
        if (ctrl_en && !blank) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                an_lit[k] = (idx == 3'(k));
            end
            if (raw_sh) seg_lit = (idx < 3'd4) ? raw_bits : 7'd0;
            else        seg_lit = hex7(nib);
            dp_lit = mask_sh[{1'b0, idx}];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            an  <= {NUM_DIGITS{UNLIT}};
            seg <= {7{UNLIT}};
            dp  <= UNLIT;
        end else begin
            an  <= an_lit ^ {NUM_DIGITS{UNLIT}};
            seg <= seg_lit ^ {7{UNLIT}};
            dp  <= dp_lit ^ UNLIT;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: directed self-checking bench for ssd_scan_ctrl
// (AXI register access, scan timing, shadowing, masks, raw, reset).
module tb_ssd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [4:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ssd_scan_ctrl #(
        .NUM_DIGITS(4),
        .ADDR_WIDTH(5),
        .PRESCALE_RST(100000),
        .ACTIVE_LOW(1)
    ) dut (
        .ACLK(clk),
        .ARESET(rst),
        .S_AXI_AWADDR(awaddr),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),
        .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp),
        .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata),
        .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready),
        .an(an),
        .seg(seg),
        .dp(dp)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [1:0] r);
        int n;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        #1;
        n = 0;
        while (!(awready && wready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("awready", {31'd0, awready & wready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("bvalid", {31'd0, bvalid}, 32'd1);
        r = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d,
                      output logic [1:0] r);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("arready", {31'd0, arready}, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("rvalid", {31'd0, rvalid}, 32'd1);
        d = rdata;
        r = rresp;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    // active-low glyphs, bit0 = a
    localparam logic [6:0] G1 = 7'h79;
    localparam logic [6:0] G2 = 7'h24;
    localparam logic [6:0] G3 = 7'h30;
    localparam logic [6:0] G4 = 7'h19;
    localparam logic [6:0] G9 = 7'h10;

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [3:0]  e_an;
        logic [6:0]  glyph [4];
        glyph[0] = G1; glyph[1] = G2; glyph[2] = G3; glyph[3] = G4;

        clks(3);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'd1);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        wr(5'h04, 32'h0000_1234, 4'hF, r);
        check("data_bresp", {30'd0, r}, 32'd0);
        rd(5'h04, d, r);
        check("data_rd", d, 32'h0000_1234);
        check("data_rresp", {30'd0, r}, 32'd0);

        wr(5'h04, 32'h0000_FFFF, 4'h1, r);
        rd(5'h04, d, r);
        check("strb_rd", d, 32'h0000_12FF);

        wr(5'h14, 32'hDEAD_BEEF, 4'hF, r);
        check("unmap_bresp", {30'd0, r}, 32'd2);
        rd(5'h04, d, r);
        check("unmap_nochg", d, 32'h0000_12FF);
        wr(5'h10, 32'hFFFF_FFFF, 4'hF, r);
        check("status_bresp", {30'd0, r}, 32'd2);
        rd(5'h18, d, r);
        check("unmap_rdata", d, 32'd0);
        check("unmap_rresp", {30'd0, r}, 32'd2);
        rd(5'h10, d, r);
        check("status_rresp", {30'd0, r}, 32'd0);
        check("status_idle", d, 32'd0);

        wr(5'h0C, 32'd0, 4'hF, r);
        rd(5'h0C, d, r);
        check("pre_zero", d, 32'd1);

        wr(5'h04, 32'h0000_4321, 4'hF, r);
        wr(5'h0C, 32'd3, 4'hF, r);
        wr(5'h00, 32'd1, 4'hF, r);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) clks(1);
            e_an = ~(4'b0001 << (i / 3));
            check($sformatf("scan_an%0d", i), {28'd0, an}, {28'd0, e_an});
            if (i % 3 == 0)
                check($sformatf("scan_seg%0d", i / 3), {25'd0, seg},
                      {25'd0, glyph[i / 3]});
        end
        check("scan_dp", {31'd0, dp}, 32'd1);
        rd(5'h10, d, r);
        check("frame1", d, 32'h0001_0000);

        wr(5'h00, 32'd0, 4'hF, r);
        check("off_an", {28'd0, an}, 32'hF);
        check("off_seg", {25'd0, seg}, 32'h7F);
        rd(5'h10, d, r);
        check("off_status", d, 32'd0);

        wr(5'h00, 32'd1, 4'hF, r);
        clks(5);
        wr(5'h04, 32'h0000_9999, 4'hF, r);
        check("sh_an2", {28'd0, an}, 32'hB);
        check("sh_seg2", {25'd0, seg}, {25'd0, G3});
        clks(2);
        check("sh_an3", {28'd0, an}, 32'h7);
        check("sh_seg3", {25'd0, seg}, {25'd0, G4});
        clks(3);
        check("sh_an0", {28'd0, an}, 32'hE);
        check("sh_seg0", {25'd0, seg}, {25'd0, G9});
        clks(3);
        check("sh_an1", {28'd0, an}, 32'hD);
        check("sh_seg1", {25'd0, seg}, {25'd0, G9});

        wr(5'h00, 32'd0, 4'hF, r);
        wr(5'h08, 32'h0000_0201, 4'hF, r);
        wr(5'h00, 32'd1, 4'hF, r);
        check("mk_an0", {28'd0, an}, 32'hE);
        check("mk_dp0", {31'd0, dp}, 32'd0);
        check("mk_seg0", {25'd0, seg}, {25'd0, G9});
        clks(3);
        check("mk_an1", {28'd0, an}, 32'hF);
        check("mk_seg1", {25'd0, seg}, 32'h7F);
        check("mk_dp1", {31'd0, dp}, 32'd1);
        clks(3);
        check("mk_an2", {28'd0, an}, 32'hB);
        check("mk_dp2", {31'd0, dp}, 32'd1);

        wr(5'h00, 32'd0, 4'hF, r);
        wr(5'h08, 32'd0, 4'hF, r);
        wr(5'h04, 32'h0000_0055, 4'hF, r);
        wr(5'h00, 32'd3, 4'hF, r);
        check("raw_an", {28'd0, an}, 32'hE);
        check("raw_seg", {25'd0, seg}, 32'h2A);

        clks(4);
        @(negedge clk);
        awaddr = 5'h04; wdata = 32'h1; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("pend_bvalid", {31'd0, bvalid}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ar_bvalid", {31'd0, bvalid}, 32'd0);
        check("ar_an", {28'd0, an}, 32'hF);
        check("ar_seg", {25'd0, seg}, 32'h7F);
        @(negedge clk);
        rst = 1'b0;
        rd(5'h0C, d, r);
        check("ar_pre", d, 32'd100000);
        rd(5'h00, d, r);
        check("ar_ctrl", d, 32'd0);
        rd(5'h04, d, r);
        check("ar_data", d, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
